// File: rtl/instr_encoder.sv
// Packs RISC-V R/I/S/B field tuples into 32-bit instruction words and streams
// them to instruction memory at consecutive word addresses through a one-word buffer.
module instr_encoder #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   input  logic              in_last,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   COUNT_MAX = '1;

   state_t      state;
   logic        accept;
   logic        xfer;
   logic        imm_ok;
   logic [31:0] enc_word;

   function automatic logic [31:0] encode(
      input logic [1:0]  fmt,
      input logic [6:0]  opcode,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [2:0]  funct3,
      input logic [6:0]  funct7,
      input logic [31:0] imm
   );
      logic [31:0] word;
      case (fmt)
         2'd0:    word = {funct7, rs2, rs1, funct3, rd, opcode};
         2'd1:    word = {imm[11:0], rs1, funct3, rd, opcode};
         2'd2:    word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         2'd3:    word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         default: word = 32'h0000_0000;
      endcase
      return word;
   endfunction

   // I/S take a signed 12-bit immediate; B takes a signed 13-bit even byte offset.
   function automatic logic imm_in_range(
      input logic [1:0]  fmt,
      input logic [31:0] imm
   );
      logic ok;
      case (fmt)
         2'd0:       ok = 1'b1;
         2'd1, 2'd2: ok = (imm[31:11] == 21'h00_0000) || (imm[31:11] == 21'h1F_FFFF);
         2'd3:       ok = ((imm[31:12] == 20'h0_0000) || (imm[31:12] == 20'hF_FFFF)) && !imm[0];
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign in_ready = (state == RUN) && (!mem_we || mem_ready);
   assign accept   = in_valid && in_ready;
   assign xfer     = mem_we && mem_ready;
   assign imm_ok   = imm_in_range(in_fmt, in_imm);
   assign enc_word = encode(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);

   // Sequencer, output buffer, address/count tracking and sticky range error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         mem_we    <= 1'b0;
         mem_addr  <= BASE;
         mem_wdata <= 32'h0000_0000;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         count     <= '0;
      end else begin
         done <= 1'b0;
         // mem_addr points at the buffered word, or at the next free slot when empty.
         if (xfer) begin
            mem_addr <= mem_addr + ADDR_W'(1);
            if (count != COUNT_MAX) begin
               count <= count + (ADDR_W+1)'(1);
            end
         end
         if (accept && imm_ok) begin
            mem_we    <= 1'b1;
            mem_wdata <= enc_word;
         end else if (xfer) begin
            mem_we <= 1'b0;
         end
         if (accept && !imm_ok) begin
            err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  mem_addr <= BASE;
                  count    <= '0;
                  err      <= 1'b0;
               end
            end
            RUN: begin
               if (accept && in_last) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!mem_we || mem_ready) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder against a queue-based model
// of the instruction words and addresses that must reach memory.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset, start, in_valid, in_last, mem_ready;
   logic [1:0]  in_fmt;
   logic [6:0]  in_opcode, in_funct7;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [31:0] in_imm;

   logic        in_ready, mem_we, busy, done, err;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [10:0] count;

   logic        s_in_ready, s_mem_we, s_busy, s_done, s_err;
   logic [1:0]  s_mem_addr;
   logic [31:0] s_mem_wdata;
   logic [2:0]  s_count;

   instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) u_dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
      .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .err(err), .count(count));

   instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
      .mem_we(s_mem_we), .mem_ready(mem_ready), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .busy(s_busy), .done(s_done), .err(s_err), .count(s_count));

   always #5 clk = ~clk;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   int          vectors = 0;
   int          miscompares = 0;
   wr_t         exp_q[$];
   logic [31:0] xfer_data[$];
   time         xfer_t[$];
   int          exp_next, exp_words;
   bit          exp_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference encoding built from field positions with plain arithmetic.
   function automatic logic [31:0] ref_enc(int fmt, int op, int rd, int rs1, int rs2,
                                          int f3, int f7, int imm);
      int w;
      w = op + (f3 << 12) + (rs1 << 15);
      case (fmt)
         0:       w += (rd << 7) + (rs2 << 20) + (f7 << 25);
         1:       w += (rd << 7) + ((imm & 32'hFFF) << 20);
         2:       w += ((imm & 32'h1F) << 7) + (rs2 << 20) + (((imm >>> 5) & 32'h7F) << 25);
         default: w += (((imm >>> 11) & 1) << 7) + (((imm >>> 1) & 32'hF) << 8) + (rs2 << 20)
                     + (((imm >>> 5) & 32'h3F) << 25) + (((imm >>> 12) & 1) << 31);
      endcase
      return w;
   endfunction

   function automatic bit ref_ok(int fmt, int imm);
      case (fmt)
         0:       return 1'b1;
         1, 2:    return (imm >= -2048) && (imm <= 2047);
         default: return (imm >= -4096) && (imm <= 4095) && ((imm % 2) == 0);
      endcase
   endfunction

   // Every memory transfer must match the next expected word, on both instances.
   always @(negedge clk) begin : mon
      wr_t w;
      if (reset === 1'b0 && mem_we === 1'b1 && mem_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
         end else begin
            w = exp_q.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(w.addr % 1024));
            chk("wr_data", mem_wdata, w.data);
            chk("small_addr", 32'(s_mem_addr), 32'(w.addr % 4));
            chk("small_data", s_mem_wdata, w.data);
         end
         xfer_data.push_back(mem_wdata);
         xfer_t.push_back($time);
      end
   end

   task automatic send(input int fmt, input int op, input int rd, input int rs1, input int rs2,
                       input int f3, input int f7, input int imm, input bit last, input bit rnd);
      int n = 0;
      in_fmt = 2'(fmt); in_opcode = 7'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1);
      in_rs2 = 5'(rs2); in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = imm;
      in_valid = 1'b1; in_last = last;
      if (rnd) mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         if (rnd) mem_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", 32'(n < 100), 32'd1);
      if (in_ready) begin
         if (ref_ok(fmt, imm)) begin
            wr_t w;
            w.addr = exp_next;
            w.data = ref_enc(fmt, op, rd, rs1, rs2, f3, f7, imm);
            exp_q.push_back(w);
            exp_next++;
            exp_words++;
         end else begin
            exp_err = 1'b1;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic start_prog();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      exp_next = 0; exp_words = 0; exp_err = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic finish_prog(input bit rnd);
      int n = 0;
      @(negedge clk);
      while (!done && n < 200) begin
         @(posedge clk); #1;
         if (rnd) mem_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      chk("done_timeout", 32'(n < 200), 32'd1);
      chk("busy_in_done", 32'(busy), 32'd0);
      @(posedge clk); #1;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("count", 32'(count), 32'(exp_words));
      chk("small_count", 32'(s_count), 32'((exp_words > 7) ? 7 : exp_words));
      chk("err", 32'(err), 32'(exp_err));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] word_a;
      int          nw, fmt, imm;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b1;
      in_fmt = 2'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
      in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
      exp_next = 0; exp_words = 0; exp_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // R add, single word program
      start_prog();
      send(0, 32'h33, 3, 1, 2, 0, 0, 0, 1'b1, 1'b0);
      finish_prog(1'b0);
      chk("r_add_word", xfer_data[xfer_data.size()-1], 32'h002081B3);

      // addi, sw, beq back to back
      xfer_data.delete(); xfer_t.delete();
      start_prog();
      send(1, 32'h13, 1, 0, 0, 0, 0, 5, 1'b0, 1'b0);
      send(2, 32'h23, 0, 1, 2, 2, 0, 8, 1'b0, 1'b0);
      send(3, 32'h63, 0, 1, 2, 0, 0, -4, 1'b1, 1'b0);
      finish_prog(1'b0);
      chk("addi_word", xfer_data[0], 32'h00500093);
      chk("sw_word", xfer_data[1], 32'h0020A423);
      chk("beq_word", xfer_data[2], 32'hFE208EE3);
      chk("b2b_spacing", 32'(xfer_t[1] - xfer_t[0]), 32'd10);

      // out-of-range immediates are swallowed and flagged
      start_prog();
      send(1, 32'h13, 1, 0, 0, 0, 0, 2048, 1'b0, 1'b0);
      send(3, 32'h63, 0, 1, 2, 0, 0, 3, 1'b0, 1'b0);
      @(negedge clk);
      chk("bad_no_we", 32'(mem_we), 32'd0);
      chk("bad_err", 32'(err), 32'd1);
      chk("bad_count", 32'(count), 32'd0);
      @(posedge clk); #1;
      send(0, 32'h33, 4, 5, 6, 0, 32'h20, 0, 1'b1, 1'b0);
      finish_prog(1'b0);
      start_prog();
      chk("start_clears_err", 32'(err), 32'd0);
      send(0, 32'h33, 1, 1, 1, 0, 0, 0, 1'b1, 1'b0);
      finish_prog(1'b0);

      // memory back-pressure holds the buffered word
      start_prog();
      mem_ready = 1'b0;
      send(1, 32'h13, 7, 3, 0, 0, 0, -1, 1'b0, 1'b0);
      word_a = ref_enc(1, 32'h13, 7, 3, 0, 0, 0, -1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_we", 32'(mem_we), 32'd1);
         chk("stall_addr", 32'(mem_addr), 32'd0);
         chk("stall_wdata", mem_wdata, word_a);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      send(2, 32'h23, 0, 8, 9, 2, 0, -2048, 1'b1, 1'b0);
      finish_prog(1'b0);

      // address wrap on the narrow instance and count saturation
      start_prog();
      for (int i = 0; i < 9; i++) send(0, 32'h33, i, i + 1, i + 2, 0, 0, 0, i == 8, 1'b0);
      finish_prog(1'b0);
      chk("wide_addr_end", 32'(mem_addr), 32'd9);
      chk("small_addr_end", 32'(s_mem_addr), 32'd1);

      // randomized programs with random memory back-pressure
      for (int p = 0; p < 4; p++) begin
         start_prog();
         nw = int'($urandom_range(10, 30));
         for (int i = 0; i < nw; i++) begin
            fmt = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) imm = int'($urandom);
            else if (fmt == 3) imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
            else imm = int'($urandom_range(0, 4095)) - 2048;
            send(fmt, int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 127)), imm,
                 i == nw - 1, 1'b1);
         end
         finish_prog(1'b1);
      end

      // reset while a word is buffered abandons it
      start_prog();
      mem_ready = 1'b0;
      send(0, 32'h33, 9, 9, 9, 0, 0, 0, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      chk("mid_rst_we", 32'(mem_we), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_addr", 32'(mem_addr), 32'd0);
      chk("mid_rst_wdata", mem_wdata, 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      exp_q.delete();
      mem_ready = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_no_we", 32'(mem_we), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the instruction decode stage: packs RISC-V R/I/S/B field tuples into 32-bit instruction words and streams them into instruction memory at consecutive word addresses. Used by the bench/boot loader path to build test programs for the matmul core without a pre-assembled image. Valid/ready input with a single-entry registered output buffer toward the memory write port, plus range checking of immediates.

Parameters:
ADDR_W, 10, instruction-memory word-address width
BASE_ADDR, 0, first word address written after start

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse in IDLE; loads address counter with BASE_ADDR, clears err/count, enters RUN
in_valid  input  1  field tuple valid
in_ready  output  1  encoder can accept tuple this cycle
in_fmt  input  2  0=R, 1=I, 2=S, 3=B
in_opcode  input  7  opcode field
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3
in_funct7  input  7  funct7 (R only)
in_imm  input  32  signed byte immediate (I/S/B)
in_last  input  1  tuple is final word of program
mem_we  output  1  write request valid
mem_ready  input  1  memory accepts write; transfer when mem_we && mem_ready
mem_addr  output  ADDR_W  word address of write
mem_wdata  output  32  encoded instruction
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse after final word transferred
err  output  1  sticky immediate-range error, cleared by start or reset
count  output  ADDR_W+1  words transferred since start

Behaviour:
- Reset (async): state IDLE; in_ready, mem_we, busy, done, err = 0; mem_addr = BASE_ADDR; mem_wdata = 0; count = 0. Reset mid-program abandons buffered word, no write issued.
- FSM: IDLE -start-> RUN; RUN -accept with in_last-> DRAIN; DRAIN -buffered word transferred (or buffer empty)-> DONE; DONE -> IDLE next cycle, done = 1 in DONE only. start ignored outside IDLE; in_ready = 0 outside RUN.
- in_ready (RUN) = !mem_we || mem_ready (buffer empty or draining same cycle). Accept = in_valid && in_ready.
- Latency: tuple accepted at edge N -> mem_we/mem_addr/mem_wdata valid from cycle after N; held stable while mem_ready = 0.
- Encoding:
  R: funct7 | rs2 | rs1 | funct3 | rd | opcode
  I: imm[11:0] | rs1 | funct3 | rd | opcode
  S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode
  B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode
  Unused fields per format ignored (R ignores in_imm; I ignores rs2/funct7; S/B ignore rd/funct7).
- Range check: I/S require in_imm[31:11] all equal (signed 12-bit); B requires in_imm[31:12] all equal and in_imm[0] = 0. Failing tuple is accepted (handshake completes) but not written: no mem_we, address and count unchanged, err set. in_last on a failing tuple still ends the program (-> DRAIN).
- Address: mem_addr advances by 1 after each transfer; wraps modulo 2^ADDR_W (no error). count saturates at 2^(ADDR_W+1)-1.
- Simultaneous transfer and accept in same cycle: buffer refilled with new word at next address, no bubble; back-to-back throughput 1 word/cycle when mem_ready stays high.
- Encoder output round-trips through the decode stage: decoded fields and sign-extended immediate equal the inputs for any in-range tuple.

Test Plan:
- start, R add (opc 0x33, rd 3, rs1 1, rs2 2, f3 0, f7 0), mem_ready=1 -> one write addr 0, data 0x002081B3, count 1.
- I addi (opc 0x13, rd 1, rs1 0, imm 5) then S sw (opc 0x23, f3 2, rs1 1, rs2 2, imm 8) back-to-back -> data 0x00500093 @0, 0x0020A423 @1 on consecutive cycles.
- B beq (opc 0x63, f3 0, rs1 1, rs2 2, imm -4, in_last) -> data 0xFE208EE3, then DRAIN, done pulse one cycle, busy drops, back to IDLE.
- I imm 2048, then B imm 3 -> no writes, err = 1, count 0; next valid tuple written at BASE_ADDR; new start clears err.
- mem_ready low 3 cycles with word buffered -> mem_we/addr/wdata stable, in_ready = 0; released -> transfer, in_ready = 1 same cycle.
- ADDR_W=2, 5 R words -> addresses 0,1,2,3,0, count 5; assert reset mid-stream -> all outputs to reset values immediately, pending word never written.
